// File: rtl/cla_share_ctrl.sv
// Round-robin share of one external 15-bit CLA add/sub between two requesters.
// Accept -> response pulse after SETTLE+1 cycles; readys held low while an op is in flight.
module cla_share_ctrl #(
    parameter int WIDTH  = 15,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_ovf,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_ovf,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_addsub,
    input  logic [WIDTH-1:0] dp_sum,
    input  logic             dp_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          owner;
    logic          gnt0;
    logic          gnt1;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                gnt0 = req0_valid && (!req1_valid || last_grant);
                gnt1 = req1_valid && (!req0_valid || !last_grant);
                if (gnt0 || gnt1) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy       = (state == WAIT) || (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_addsub  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_sum   <= '0;
            rsp0_ovf   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_sum   <= '0;
            rsp1_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        dp_a       <= gnt1 ? req1_a : req0_a;
                        dp_b       <= gnt1 ? req1_b : req0_b;
                        dp_addsub  <= gnt1 ? req1_sub : req0_sub;
                        owner      <= gnt1;
                        last_grant <= gnt1;
                        cnt        <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // dp_* have been stable for SETTLE edges: the CLA output is valid now.
                    if (cnt == CNT_LAST) begin
                        if (owner) begin
                            rsp1_valid <= 1'b1;
                            rsp1_sum   <= dp_sum;
                            rsp1_ovf   <= dp_ovf;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_sum   <= dp_sum;
                            rsp0_ovf   <= dp_ovf;
                        end
                    end
                end
                RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_share_ctrl.sv
// Bench for cla_share_ctrl: two instances (SETTLE=1 and SETTLE=3), each driving a
// behavioural CLA whose output is corrupted until the operands have settled.
module tb_cla_share_ctrl;

    localparam int W  = 15;
    localparam int S1 = 1;
    localparam int S3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         req0_valid, req0_ready, req0_sub, rsp0_valid, rsp0_ovf;
    logic         req1_valid, req1_ready, req1_sub, rsp1_valid, rsp1_ovf;
    logic [W-1:0] req0_a, req0_b, rsp0_sum, req1_a, req1_b, rsp1_sum;
    logic [W-1:0] dp_a, dp_b, dp_sum;
    logic         dp_addsub, dp_ovf, busy;

    logic         s3_req0_valid, s3_req0_ready, s3_req0_sub, s3_rsp0_valid, s3_rsp0_ovf;
    logic         s3_req1_valid, s3_req1_ready, s3_req1_sub, s3_rsp1_valid, s3_rsp1_ovf;
    logic [W-1:0] s3_req0_a, s3_req0_b, s3_rsp0_sum, s3_req1_a, s3_req1_b, s3_rsp1_sum;
    logic [W-1:0] dp3_a, dp3_b, dp3_sum;
    logic         dp3_addsub, dp3_ovf, busy3;

    int tests = 0;
    int fails = 0;

    cla_share_ctrl #(.WIDTH(W), .SETTLE(S1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sub(req0_sub), .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_ovf(rsp0_ovf),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sub(req1_sub), .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_ovf(rsp1_ovf),
        .dp_a(dp_a), .dp_b(dp_b), .dp_addsub(dp_addsub), .dp_sum(dp_sum), .dp_ovf(dp_ovf),
        .busy(busy)
    );

    cla_share_ctrl #(.WIDTH(W), .SETTLE(S3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s3_req0_valid), .req0_ready(s3_req0_ready), .req0_a(s3_req0_a),
        .req0_b(s3_req0_b), .req0_sub(s3_req0_sub), .rsp0_valid(s3_rsp0_valid),
        .rsp0_sum(s3_rsp0_sum), .rsp0_ovf(s3_rsp0_ovf),
        .req1_valid(s3_req1_valid), .req1_ready(s3_req1_ready), .req1_a(s3_req1_a),
        .req1_b(s3_req1_b), .req1_sub(s3_req1_sub), .rsp1_valid(s3_rsp1_valid),
        .rsp1_sum(s3_rsp1_sum), .rsp1_ovf(s3_rsp1_ovf),
        .dp_a(dp3_a), .dp_b(dp3_b), .dp_addsub(dp3_addsub), .dp_sum(dp3_sum), .dp_ovf(dp3_ovf),
        .busy(busy3)
    );

    // {ovf, sum}: exact signed result, wrapped to W bits, overflow when out of range.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
        int          r;
        logic [31:0] u;
        r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        u = r;
        return {(r > 16383) || (r < -16384), u[W-1:0]};
    endfunction

    // Behavioural CLA: output is inverted garbage until operands have been stable
    // long enough to be sampled on the SETTLE-th edge after they changed.
    time          chg_m = 0;
    time          chg_3 = 0;
    logic [2*W:0] last_m, last_3;
    always begin
        @(clk);
        #1;
        if ({dp_a, dp_b, dp_addsub} !== last_m) begin
            last_m = {dp_a, dp_b, dp_addsub};
            chg_m  = $time;
        end
        if ({dp3_a, dp3_b, dp3_addsub} !== last_3) begin
            last_3 = {dp3_a, dp3_b, dp3_addsub};
            chg_3  = $time;
        end
        if (($time - chg_m) >= time'(S1 * 10 - 5)) {dp_ovf, dp_sum} = ref_op(dp_a, dp_b, dp_addsub);
        else {dp_ovf, dp_sum} = ~ref_op(dp_a, dp_b, dp_addsub);
        if (($time - chg_3) >= time'(S3 * 10 - 5)) {dp3_ovf, dp3_sum} = ref_op(dp3_a, dp3_b, dp3_addsub);
        else {dp3_ovf, dp3_sum} = ~ref_op(dp3_a, dp3_b, dp3_addsub);
    end

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_ovf, rsp1_ovf, busy} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_ovf, rsp1_ovf, busy});
        end
        tests++;
        if ({rsp0_sum, rsp1_sum, dp_a, dp_b, dp_addsub} !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", {rsp0_sum, rsp1_sum, dp_a, dp_b, dp_addsub});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, req0_ready, req1_ready, busy3} !== 4'b0) begin
            fails++;
            $display("FAIL reset_idle: got %b expected 0000", {busy, req0_ready, req1_ready, busy3});
        end
    endtask

    task automatic test_single(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub);
        logic [W:0] e;
        int         k;
        e = ref_op(a, b, sub);
        @(posedge clk);
        #1;
        if (n == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end
        @(negedge clk);
        k = 0;
        while (((n == 0) ? req0_ready : req1_ready) !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 10) begin
            fails++;
            $display("FAIL single_grant: req%0d got no ready, required ready within 10 cycles", n);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom_range(0, 1));
        req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom_range(0, 1));
        @(negedge clk);
        tests++;
        if ({busy, req0_ready, req1_ready} !== 3'b100) begin
            fails++;
            $display("FAIL single_wait_flags: busy/rdy0/rdy1 got %b expected 100", {busy, req0_ready, req1_ready});
        end
        tests++;
        if ({dp_a, dp_b, dp_addsub} !== {a, b, sub}) begin
            fails++;
            $display("FAIL single_dp_drive: got %h/%h/%b expected %h/%h/%b", dp_a, dp_b, dp_addsub, a, b, sub);
        end
        k = 0;
        while (((n == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k !== S1) begin
            fails++;
            $display("FAIL single_latency: req%0d rsp after %0d cycles, expected %0d", n, k, S1);
        end
        tests++;
        if (((n == 0) ? {rsp0_ovf, rsp0_sum} : {rsp1_ovf, rsp1_sum}) !== e) begin
            fails++;
            $display("FAIL single_result: req%0d a=%h b=%h sub=%b got ovf/sum %h expected %h", n, a, b, sub,
                     (n == 0) ? {rsp0_ovf, rsp0_sum} : {rsp1_ovf, rsp1_sum}, e);
        end
        tests++;
        if (((n == 0) ? rsp1_valid : rsp0_valid) !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_rsp_excl: other rsp_valid=%b busy=%b expected 0/1",
                     (n == 0) ? rsp1_valid : rsp0_valid, busy);
        end
        @(negedge clk);
        tests++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            fails++;
            $display("FAIL single_pulse_end: got %b expected 000", {rsp0_valid, rsp1_valid, busy});
        end
        tests++;
        if (((n == 0) ? {rsp0_ovf, rsp0_sum} : {rsp1_ovf, rsp1_sum}) !== e) begin
            fails++;
            $display("FAIL single_hold: got %h expected %h",
                     (n == 0) ? {rsp0_ovf, rsp0_sum} : {rsp1_ovf, rsp1_sum}, e);
        end
    endtask

    task automatic test_round_robin;
        logic [W-1:0] a0, b0, a1, b1;
        logic         s0, s1, exp_last, exp_g;
        logic [W:0]   e0, e1;
        int           q[$];
        int           grants, rsps, owner, exp_owner;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        a0 = W'($urandom); b0 = W'($urandom); s0 = 1'($urandom_range(0, 1));
        a1 = a0 ^ 15'h5555; b1 = b0 ^ 15'h2AAA; s1 = ~s0;
        e0 = ref_op(a0, b0, s0);
        e1 = ref_op(a1, b1, s1);
        req0_valid = 1'b1; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = 1'b1; req1_a = a1; req1_b = b1; req1_sub = s1;
        exp_last = 1'b1;
        grants = 0;
        rsps = 0;
        for (int it = 0; it < 60 && rsps < 4; it++) begin
            @(negedge clk);
            tests++;
            if ((req0_ready === 1'b1 && req1_ready === 1'b1) || (rsp0_valid === 1'b1 && rsp1_valid === 1'b1)) begin
                fails++;
                $display("FAIL rr_exclusive: rdy=%b%b rsp=%b%b expected never both", req0_ready, req1_ready,
                         rsp0_valid, rsp1_valid);
            end
            if ((req0_ready === 1'b1 || req1_ready === 1'b1) && grants < 4) begin
                exp_g = ~exp_last;
                tests++;
                if (req1_ready !== exp_g) begin
                    fails++;
                    $display("FAIL rr_grant: grant %0d went to req%0d, expected req%0d", grants, req1_ready, exp_g);
                end
                exp_last = exp_g;
                q.push_back(int'(exp_g));
                grants++;
            end
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
                owner = (rsp1_valid === 1'b1) ? 1 : 0;
                exp_owner = (q.size() > 0) ? q.pop_front() : -1;
                rsps++;
                tests++;
                if (owner != exp_owner || (owner == 1 ? {rsp1_ovf, rsp1_sum} : {rsp0_ovf, rsp0_sum}) !== (owner == 1 ? e1 : e0)) begin
                    fails++;
                    $display("FAIL rr_response: rsp to req%0d value %h, expected req%0d value %h", owner,
                             owner == 1 ? {rsp1_ovf, rsp1_sum} : {rsp0_ovf, rsp0_sum}, exp_owner,
                             exp_owner == 1 ? e1 : e0);
                end
            end
            @(posedge clk);
            #1;
            if (grants == 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tests++;
        if (rsps != 4) begin
            fails++;
            $display("FAIL rr_done: got %0d responses, expected 4 within 60 cycles", rsps);
        end
    endtask

    task automatic test_back_to_back;
        int         cyc, last_acc, n_acc;
        logic       pend, exp_busy, exp_rdy;
        logic [W:0] q[$];
        logic [W:0] got;
        cyc = 0; last_acc = 0; n_acc = 0; pend = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom_range(0, 1));
        for (int it = 0; it < 24; it++) begin
            @(negedge clk);
            exp_busy = (n_acc > 0) && (cyc - last_acc <= S1);
            exp_rdy  = req0_valid && !exp_busy;
            tests++;
            if (busy !== exp_busy || req0_ready !== exp_rdy) begin
                fails++;
                $display("FAIL b2b_timing: cycle %0d busy/ready got %b%b expected %b%b", cyc, busy, req0_ready,
                         exp_busy, exp_rdy);
            end
            if (rsp0_valid === 1'b1) begin
                got = {rsp0_ovf, rsp0_sum};
                tests++;
                if (q.size() == 0 || got !== q[0]) begin
                    fails++;
                    $display("FAIL b2b_result: got %h expected %h", got, (q.size() > 0) ? q[0] : '0);
                end
                if (q.size() > 0) q.pop_front();
            end
            if (req0_ready === 1'b1) begin
                q.push_back(ref_op(req0_a, req0_b, req0_sub));
                pend = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (pend) begin
                pend = 1'b0;
                last_acc = cyc;
                n_acc++;
                if (n_acc == 5) req0_valid = 1'b0;
                else begin
                    req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom_range(0, 1));
                end
            end
        end
        req0_valid = 1'b0;
        tests++;
        if (n_acc != 5 || q.size() != 0) begin
            fails++;
            $display("FAIL b2b_count: accepts %0d pending %0d, expected 5 and 0", n_acc, q.size());
        end
    endtask

    task automatic test_reset_mid;
        int         k;
        logic       seen;
        logic [W:0] e;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'b0;
        @(negedge clk);
        k = 0;
        while (req0_ready !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0 ||
            {dp_a, dp_b, dp_addsub, rsp0_sum, rsp1_sum, rsp0_ovf, rsp1_ovf} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: flags %b dp %h/%h expected all 0",
                     {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, dp_a, dp_b);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_pulse: got response pulse, expected none");
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'b1;
        req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'b0;
        e = ref_op(req0_a, req0_b, req0_sub);
        @(negedge clk);
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL midreset_grant: rdy0/rdy1 got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (rsp0_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if ({rsp0_ovf, rsp0_sum} !== e) begin
            fails++;
            $display("FAIL midreset_after: got %h expected %h", {rsp0_ovf, rsp0_sum}, e);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_settle3;
        logic [W-1:0] a, b;
        logic         sub;
        logic [W:0]   e;
        int           k;
        for (int i = 0; i < 3; i++) begin
            a   = (i == 0) ? 15'h0005 : W'($urandom);
            b   = (i == 0) ? 15'h0003 : W'($urandom);
            sub = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            e   = ref_op(a, b, sub);
            @(posedge clk);
            #1;
            s3_req0_valid = 1'b1; s3_req0_a = a; s3_req0_b = b; s3_req0_sub = sub;
            @(negedge clk);
            k = 0;
            while (s3_req0_ready !== 1'b1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            tests++;
            if (k >= 10) begin
                fails++;
                $display("FAIL s3_grant: got no ready, required ready within 10 cycles");
                s3_req0_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            s3_req0_valid = 1'b0;
            s3_req0_a = W'($urandom); s3_req0_b = W'($urandom); s3_req0_sub = ~sub;
            @(negedge clk);
            k = 0;
            while (s3_rsp0_valid !== 1'b1 && k < 20) begin
                tests++;
                if ({dp3_a, dp3_b, dp3_addsub} !== {a, b, sub}) begin
                    fails++;
                    $display("FAIL s3_dp_stable: cycle %0d got %h/%h/%b expected %h/%h/%b", k, dp3_a, dp3_b,
                             dp3_addsub, a, b, sub);
                end
                @(negedge clk);
                k++;
            end
            tests++;
            if (k !== S3) begin
                fails++;
                $display("FAIL s3_latency: rsp after %0d cycles, expected %0d", k, S3);
            end
            tests++;
            if ({s3_rsp0_ovf, s3_rsp0_sum} !== e) begin
                fails++;
                $display("FAIL s3_result: got %h expected %h", {s3_rsp0_ovf, s3_rsp0_sum}, e);
            end
            @(negedge clk);
            tests++;
            if ({s3_rsp0_valid, busy3} !== 2'b00) begin
                fails++;
                $display("FAIL s3_pulse_end: rsp_valid/busy got %b expected 00", {s3_rsp0_valid, busy3});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        s3_req0_valid = 1'b0; s3_req0_a = '0; s3_req0_b = '0; s3_req0_sub = 1'b0;
        s3_req1_valid = 1'b0; s3_req1_a = '0; s3_req1_b = '0; s3_req1_sub = 1'b0;
        test_reset;
        test_single(0, 15'h0005, 15'h0003, 1'b0);
        test_single(1, 15'h3FFF, 15'h0001, 1'b0);
        test_single(1, 15'h0000, 15'h0001, 1'b1);
        test_single(0, 15'h4000, 15'h0001, 1'b1);
        for (int i = 0; i < 12; i++) begin
            test_single(int'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        test_round_robin;
        test_back_to_back;
        test_reset_mid;
        test_settle3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
        $fatal(1);
    end

endmodule
